// File: rtl/sm_uart_msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_uart_msg_pkg
//  Description : Shared constants, parser state encoding and character
//                classification helper for the UART path-message decoder.
//                No ports (package).
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_uart_msg_pkg;

  // Framing characters
  localparam logic [7:0] CH_START = 8'h2D;  // '-'
  localparam logic [7:0] CH_SEP   = 8'h2D;  // '-'
  localparam logic [7:0] CH_END   = 8'h23;  // '#'
  localparam logic [7:0] CH_ZERO  = 8'h30;  // '0'

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // True for ASCII '0'..'9'
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= 8'h39);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_ascii_dec_acc.sv
`default_nettype none
// ============================================================================
//  Module      : sm_ascii_dec_acc
//  Description : Decimal accumulator for one path-number field. Builds
//                acc = acc*10 + digit, counts digits and flags an attempt to
//                add a digit beyond MAX_DIGITS.
//  Ports       : clk, rst        - clock, async active-high reset
//                clear           - zero acc and digit count
//                load_digit      - append digit (ignored when full)
//                digit[3:0]      - binary value of the ASCII digit
//                acc[ACC_W-1:0]  - accumulated value
//                digit_cnt       - digits in the current field
//                has_digits      - digit_cnt != 0
//                overflow        - load_digit while already MAX_DIGITS
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_ascii_dec_acc #(
  parameter int MAX_DIGITS = 2,
  parameter int ACC_W      = 4 * MAX_DIGITS,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_digit,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             has_digits,
  output logic             overflow
);

  logic             full;
  logic [ACC_W-1:0] acc_next;

  assign full       = (digit_cnt == CNT_W'(MAX_DIGITS));
  assign has_digits = (digit_cnt != '0);
  assign overflow   = load_digit && full;

  // acc*10 as (acc<<3)+(acc<<1); ACC_W=4*MAX_DIGITS always holds 10^MAX_DIGITS-1
  assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      digit_cnt <= '0;
    end else if (clear) begin
      acc       <= '0;
      digit_cnt <= '0;
    end else if (load_digit && !full) begin
      acc       <= acc_next;
      digit_cnt <= digit_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_uart_rx_path_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sm_uart_rx_path_decoder
//  Description : Parses "-<num>-<num>-...#" ASCII frames from the UART RX
//                core and publishes an atomically updated path availability
//                mask (bit=0 -> path blocked). Range check, digit limit and
//                inter-byte timeout abort a frame without touching paths_av.
//  Ports       : clk, rst        - clock, async active-high reset
//                rx_valid        - one-cycle byte strobe
//                rx_byte[7:0]    - received ASCII byte
//                paths_av        - committed availability mask
//                frame_done      - pulse: frame accepted, paths_av updated
//                frame_err       - pulse: frame aborted
//                busy            - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_uart_rx_path_decoder
  import sm_uart_msg_pkg::*;
#(
  parameter int                 N_PATHS        = 17,
  parameter logic [N_PATHS-1:0] DEFAULT_MASK   = 17'h1FF7F,
  parameter int                 MAX_DIGITS     = 2,
  parameter bit                 MERGE          = 1'b0,
  parameter int                 TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic [N_PATHS-1:0] paths_av,
  output logic               frame_done,
  output logic               frame_err,
  output logic               busy
);

  localparam int ACC_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [0:0] S_IDLE    = IDLE;
  localparam logic [0:0] S_COLLECT = COLLECT;

  logic [0:0]         state;
  logic [N_PATHS-1:0] work_mask;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   digit_cnt;
  logic               has_digits;
  logic               overflow;

  logic               in_collect;
  logic               byte_digit;
  logic               byte_sep;
  logic               byte_end;
  logic               acc_clear;
  logic               acc_load;
  logic [N_PATHS-1:0] clr_onehot;
  logic [N_PATHS-1:0] field_mask;
  logic               field_bad;
  logic               timeout;
  logic               abort;

  assign in_collect = (state == S_COLLECT);
  assign busy       = in_collect;
  assign byte_digit = is_digit(rx_byte);
  assign byte_sep   = (rx_byte == CH_SEP);
  assign byte_end   = (rx_byte == CH_END);

  // Field boundaries (and frame start, which is the same character) wipe the
  // accumulator; a stale field left by an abort is wiped by the next '-'.
  assign acc_clear = rx_valid && (byte_sep || byte_end);
  assign acc_load  = in_collect && rx_valid && byte_digit;

  sm_ascii_dec_acc #(
    .MAX_DIGITS (MAX_DIGITS),
    .ACC_W      (ACC_W),
    .CNT_W      (CNT_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .load_digit (acc_load),
    .digit      (rx_byte[3:0]),  // low nibble of '0'..'9' is the digit value
    .acc        (acc),
    .digit_cnt  (digit_cnt),
    .has_digits (has_digits),
    .overflow   (overflow)
  );

  // One-hot decode of the accumulated path number; all-zero when out of range
  for (genvar i = 0; i < N_PATHS; i++) begin : g_clr
    assign clr_onehot[i] = (int'(acc) == i);
  end

  // Mask after committing the pending field (if any); empty field is a no-op
  assign field_bad  = has_digits && !(int'(acc) < N_PATHS);
  assign field_mask = has_digits ? (work_mask & ~clr_onehot) : work_mask;

  // Inter-byte timeout: expiry is the idle cycle that would bring the timer
  // to TIMEOUT_CYCLES. A valid byte in that cycle takes priority.
  if (TIMEOUT_CYCLES > 0) begin : g_timer
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        timer <= '0;
      end else if (rx_valid || !in_collect) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end

    assign timeout = in_collect && !rx_valid &&
                     (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timer
    assign timeout = 1'b0;
  end

  always_comb begin
    abort = 1'b0;
    if (in_collect) begin
      if (rx_valid) begin
        if (byte_digit)                 abort = overflow;
        else if (byte_sep || byte_end)  abort = field_bad;
        else                            abort = 1'b1;
      end else begin
        abort = timeout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      work_mask  <= '1;
      paths_av   <= DEFAULT_MASK;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= abort;
      if (!in_collect) begin
        if (rx_valid && (rx_byte == CH_START)) begin
          state     <= S_COLLECT;
          work_mask <= MERGE ? paths_av : '1;
        end
      end else if (abort) begin
        state <= S_IDLE;
      end else if (rx_valid && byte_end) begin
        // Final commit and publication share one edge: no partial mask visible
        paths_av   <= field_mask;
        frame_done <= 1'b1;
        state      <= S_IDLE;
      end else if (rx_valid && byte_sep) begin
        work_mask <= field_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_uart_rx_path_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_uart_rx_path_decoder
//  Description : Self-checking bench. Two decoder instances (MERGE=0 and
//                MERGE=1, TIMEOUT_CYCLES=8) see the same byte stream; a
//                frame-level reference model predicts every output each cycle,
//                and literal expectations pin key results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_uart_rx_path_decoder;

  localparam logic [16:0] DEF = 17'h1FF7F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic [16:0] pa0, pa1;
  logic        fd0, fd1, fe0, fe1, bz0, bz1;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  sm_uart_rx_path_decoder #(
    .N_PATHS(17), .DEFAULT_MASK(DEF), .MAX_DIGITS(2), .MERGE(1'b0), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .paths_av(pa0), .frame_done(fd0), .frame_err(fe0), .busy(bz0)
  );

  sm_uart_rx_path_decoder #(
    .N_PATHS(17), .DEFAULT_MASK(DEF), .MAX_DIGITS(2), .MERGE(1'b1), .TIMEOUT_CYCLES(8)
  ) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .paths_av(pa1), .frame_done(fd1), .frame_err(fe1), .busy(bz1)
  );

  // ---------------- reference model (frame-level rules) ----------------
  typedef struct {
    bit          in_frame;
    logic [16:0] wm;
    int          val;
    int          nd;
    int          idle;
    logic [16:0] paths;
    bit          done;
    bit          err;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.in_frame = 0; r.wm = '1; r.val = 0; r.nd = 0; r.idle = 0;
    r.paths = DEF; r.done = 0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit merge, input bit v, input logic [7:0] b);
    mdl_t n = m;
    bit   bad;
    n.done = 0;
    n.err  = 0;
    if (!n.in_frame) begin
      if (v && b == "-") begin
        n.in_frame = 1; n.wm = merge ? n.paths : 17'h1FFFF;
        n.val = 0; n.nd = 0; n.idle = 0;
      end
    end else if (v) begin
      n.idle = 0;
      if (b >= "0" && b <= "9") begin
        if (n.nd == 2) begin n.err = 1; n.in_frame = 0; end
        else begin n.val = n.val * 10 + int'(b - "0"); n.nd = n.nd + 1; end
      end else if (b == "-" || b == "#") begin
        bad = 0;
        if (n.nd > 0) begin
          if (n.val < 17) n.wm = n.wm & ~(17'd1 << n.val);
          else bad = 1;
        end
        if (bad) begin n.err = 1; n.in_frame = 0; end
        else if (b == "#") begin n.paths = n.wm; n.done = 1; n.in_frame = 0; end
        else begin n.val = 0; n.nd = 0; end
      end else begin
        n.err = 1; n.in_frame = 0;
      end
    end else begin
      n.idle = n.idle + 1;
      if (n.idle >= 8) begin n.err = 1; n.in_frame = 0; end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= mdl_reset();
      m1 <= mdl_reset();
    end else begin
      m0 <= step(m0, 1'b0, rx_valid, rx_byte);
      m1 <= step(m1, 1'b1, rx_valid, rx_byte);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m0.paths_av",   {15'd0, pa0}, {15'd0, m0.paths});
      chk("m0.frame_done", {31'd0, fd0}, {31'd0, m0.done});
      chk("m0.frame_err",  {31'd0, fe0}, {31'd0, m0.err});
      chk("m0.busy",       {31'd0, bz0}, {31'd0, m0.in_frame});
      chk("m1.paths_av",   {15'd0, pa1}, {15'd0, m1.paths});
      chk("m1.frame_done", {31'd0, fd1}, {31'd0, m1.done});
      chk("m1.frame_err",  {31'd0, fe1}, {31'd0, m1.err});
      chk("m1.busy",       {31'd0, bz1}, {31'd0, m1.in_frame});
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; leaves time at posedge+1 after the last byte's edge
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_byte  = s[i];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    cmp_on = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state
    idle(10);
    chk("rst.paths_av", {15'd0, pa0}, 32'h1FF7F);
    chk("rst.strobes",  {29'd0, fd0, fe0, bz0}, 32'h0);
    chk("rst.paths_av1", {15'd0, pa1}, 32'h1FF7F);

    // Multi-digit frame, then a second frame
    send_str("-3-12-#");
    chk("f1.paths_av0", {15'd0, pa0}, 32'h1EFF7);
    chk("f1.done0",     {31'd0, fd0}, 32'h1);
    chk("f1.paths_av1", {15'd0, pa1}, 32'h1EF77);
    idle(2);
    send_str("-3#");
    chk("f2.paths_av0", {15'd0, pa0}, 32'h1FFF7);
    chk("f2.paths_av1", {15'd0, pa1}, 32'h1EF77);
    idle(2);

    // Range error at commit, then digit overflow
    send_str("-20-");
    chk("rng.err", {31'd0, fe0}, 32'h1);
    send_str("#");
    idle(1);
    send_str("-123");
    chk("ovf.err",      {31'd0, fe0}, 32'h1);
    chk("ovf.paths_av", {15'd0, pa0}, 32'h1FFF7);
    idle(2);

    // Garbage in IDLE, bad char in frame, then a good frame
    send_str("#x");
    idle(1);
    send_str("-1x");
    chk("bad.err", {31'd0, fe0}, 32'h1);
    idle(1);
    send_str("-5-#");
    chk("g.paths_av0", {15'd0, pa0}, 32'h1FFDF);
    idle(2);

    // Duplicate numbers and empty fields
    send_str("-2-2--#");
    chk("dup.paths_av0", {15'd0, pa0}, 32'h1FFFB);
    idle(2);

    // MERGE behaviour from reset
    do_reset();
    idle(1);
    send_str("-0#");
    chk("mrg.paths_av1", {15'd0, pa1}, 32'h1FF7E);
    idle(1);
    send_str("-#");
    chk("mrg.empty1", {15'd0, pa1}, 32'h1FF7E);
    chk("mrg.done1",  {31'd0, fd1}, 32'h1);
    chk("mrg.empty0", {15'd0, pa0}, 32'h1FFFF);
    idle(2);

    // Timeout after 8 idle cycles
    send_str("-4");
    idle(7);
    chk("tmo.busy_before", {31'd0, bz0}, 32'h1);
    idle(1);
    chk("tmo.err",      {31'd0, fe0}, 32'h1);
    chk("tmo.busy",     {31'd0, bz0}, 32'h0);
    chk("tmo.paths_av", {15'd0, pa0}, 32'h1FFFF);
    idle(2);

    // Byte arriving exactly at expiry wins
    send_str("-4");
    idle(7);
    send_str("#");
    chk("exp.done",     {31'd0, fd0}, 32'h1);
    chk("exp.paths_av", {15'd0, pa0}, 32'h1FFEF);
    idle(2);

    // Reset mid-frame discards it
    send_str("-4");
    do_reset();
    send_str("#");
    chk("rmf.paths_av", {15'd0, pa0}, 32'h1FF7F);
    chk("rmf.strobes",  {29'd0, fd0, fe0, bz0}, 32'h0);
    idle(3);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
